seq_alu: RTL and testbench

Parametrised, multicycle successor to the datapath ALU. It keeps the same 5-bit opcode map and the Hi/Lo result pair. It adds a start/done handshake, registered results, and iterative signed multiply and divide, so the block closes timing at any `WIDTH`. It sits between the register-file read ports and the Z/HI/LO latches, and the control unit sequences it with `start`/`done` instead of fixed wait states.

---
 rtl/seq_alu_if.sv | 25 ++
 rtl/seq_alu.sv | 179 +++++++++++++++++
 tb/tb_seq_alu.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
// Handshake and operand/result bundle between the control unit and seq_alu.
// The control unit drives the master side; the ALU implements the slave side.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [4:0]       Op;
  logic [WIDTH-1:0] RA;
  logic [WIDTH-1:0] RB;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] ResultHi;
  logic [WIDTH-1:0] ResultLo;

  modport master (
    output start, Op, RA, RB,
    input  busy, done, div_zero, ResultHi, ResultLo
  );

  modport slave (
    input  start, Op, RA, RB,
    output busy, done, div_zero, ResultHi, ResultLo
  );
endinterface

// File: rtl/seq_alu.sv
// Multicycle ALU: single-cycle logic/shift ops, radix-2 Booth multiply and
// restoring signed divide, all sequenced by a start/done handshake.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic       clock,
  input logic       clear,
  seq_alu_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [SHW:0] WSH = (SHW+1)'(WIDTH);

  localparam logic [4:0] OP_LOAD = 5'b00000, OP_ADD  = 5'b00011, OP_SUB  = 5'b00100,
                         OP_AND  = 5'b00101, OP_OR   = 5'b00110, OP_ROR  = 5'b00111,
                         OP_ROL  = 5'b01000, OP_SHR  = 5'b01001, OP_SHRA = 5'b01010,
                         OP_SHL  = 5'b01011, OP_ADDI = 5'b01100, OP_ANDI = 5'b01101,
                         OP_ORI  = 5'b01110, OP_DIV  = 5'b01111, OP_MUL  = 5'b10000,
                         OP_NEG  = 5'b10001, OP_NOT  = 5'b10010, OP_SHLA = 5'b10011;

  typedef enum logic [2:0] {IDLE, EXEC1, MUL_IT, DIV_IT, DIV_FIX} state_t;

  state_t           state_reg, state_next;
  logic [4:0]       op_reg;
  logic [WIDTH-1:0] ra_reg, rb_reg, dvs_reg, mq_reg, hi_reg, lo_reg;
  logic [WIDTH:0]   acc_reg;
  logic             q1_reg, done_reg, div_zero_reg;
  logic [CW-1:0]    cnt_reg;

  logic             last_step;
  logic [WIDTH-1:0] alu_hi, alu_lo;
  logic             alu_dz;
  logic [SHW-1:0]   n;
  logic [SHW:0]     inv;
  logic [WIDTH:0]   mcand_ext, booth_sum, booth_a_next;
  logic [WIDTH-1:0] booth_q_next;
  logic [WIDTH:0]   div_shift, div_diff, rem_next;
  logic [WIDTH-1:0] quo_next, abs_ra, abs_rb;

  assign last_step = (cnt_reg == CW'(WIDTH-1));
  assign abs_ra    = bus.RA[WIDTH-1] ? -bus.RA : bus.RA;
  assign abs_rb    = bus.RB[WIDTH-1] ? -bus.RB : bus.RB;

  assign bus.busy     = (state_reg != IDLE);
  assign bus.done     = done_reg;
  assign bus.div_zero = div_zero_reg;
  assign bus.ResultHi = hi_reg;
  assign bus.ResultLo = lo_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (bus.start) begin
        if (bus.Op == OP_MUL)                       state_next = MUL_IT;
        else if (bus.Op == OP_DIV && bus.RB != '0)  state_next = DIV_IT;
        else                                        state_next = EXEC1;
      end
      EXEC1:   state_next = IDLE;
      MUL_IT:  if (last_step) state_next = IDLE;
      DIV_IT:  if (last_step) state_next = DIV_FIX;
      DIV_FIX: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Single-cycle results; DIV only lands here when the divisor was zero.
  always_comb begin
    alu_hi = '0;
    alu_lo = '0;
    alu_dz = 1'b0;
    n      = rb_reg[SHW-1:0];
    inv    = WSH - {1'b0, n};
    case (op_reg)
      OP_LOAD, OP_ADD, OP_ADDI: alu_lo = ra_reg + rb_reg;
      OP_SUB:                   alu_lo = ra_reg - rb_reg;
      OP_AND, OP_ANDI:          alu_lo = ra_reg & rb_reg;
      OP_OR, OP_ORI:            alu_lo = ra_reg | rb_reg;
      OP_NEG:                   alu_lo = -rb_reg;
      OP_NOT:                   alu_lo = ~rb_reg;
      OP_SHR:                   alu_lo = ra_reg >> n;
      OP_SHRA:                  alu_lo = $unsigned($signed(ra_reg) >>> n);
      OP_SHL:                   alu_lo = ra_reg << n;
      OP_SHLA: begin
        alu_lo            = ra_reg << n;
        alu_lo[WIDTH-1]   = ra_reg[WIDTH-1];
      end
      OP_ROR:                   alu_lo = (ra_reg >> n) | (ra_reg << inv);
      OP_ROL:                   alu_lo = (ra_reg << n) | (ra_reg >> inv);
      OP_DIV: begin
        alu_lo = '1;
        alu_hi = ra_reg;
        alu_dz = 1'b1;
      end
      default: ;
    endcase
  end

  // Booth step: the accumulator is one bit wider so the most-negative multiplicand does not overflow.
  always_comb begin
    mcand_ext = {ra_reg[WIDTH-1], ra_reg};
    booth_sum = acc_reg;
    case ({mq_reg[0], q1_reg})
      2'b01:   booth_sum = acc_reg + mcand_ext;
      2'b10:   booth_sum = acc_reg - mcand_ext;
      default: booth_sum = acc_reg;
    endcase
    booth_a_next = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    booth_q_next = {booth_sum[0], mq_reg[WIDTH-1:1]};
  end

  always_comb begin
    div_shift = {acc_reg[WIDTH-1:0], mq_reg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, dvs_reg};
    rem_next  = div_diff[WIDTH] ? div_shift : div_diff;
    quo_next  = {mq_reg[WIDTH-2:0], ~div_diff[WIDTH]};
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_reg    <= IDLE;
      op_reg       <= '0;
      ra_reg       <= '0;
      rb_reg       <= '0;
      dvs_reg      <= '0;
      mq_reg       <= '0;
      acc_reg      <= '0;
      q1_reg       <= 1'b0;
      cnt_reg      <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      done_reg     <= 1'b0;
      div_zero_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      done_reg     <= 1'b0;
      div_zero_reg <= 1'b0;
      case (state_reg)
        IDLE: if (bus.start) begin
          op_reg  <= bus.Op;
          ra_reg  <= bus.RA;
          rb_reg  <= bus.RB;
          dvs_reg <= abs_rb;
          mq_reg  <= (bus.Op == OP_DIV) ? abs_ra : bus.RB;
          acc_reg <= '0;
          q1_reg  <= 1'b0;
          cnt_reg <= '0;
        end
        EXEC1: begin
          hi_reg       <= alu_hi;
          lo_reg       <= alu_lo;
          div_zero_reg <= alu_dz;
          done_reg     <= 1'b1;
        end
        MUL_IT: begin
          acc_reg <= booth_a_next;
          mq_reg  <= booth_q_next;
          q1_reg  <= mq_reg[0];
          cnt_reg <= cnt_reg + 1'b1;
          if (last_step) begin
            hi_reg   <= booth_a_next[WIDTH-1:0];
            lo_reg   <= booth_q_next;
            done_reg <= 1'b1;
          end
        end
        DIV_IT: begin
          acc_reg <= rem_next;
          mq_reg  <= quo_next;
          cnt_reg <= cnt_reg + 1'b1;
        end
        DIV_FIX: begin
          lo_reg   <= (ra_reg[WIDTH-1] ^ rb_reg[WIDTH-1]) ? -mq_reg : mq_reg;
          hi_reg   <= ra_reg[WIDTH-1] ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
          done_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu at WIDTH=32: directed vectors with expected
// results queued at issue time and checked by an independent monitor.
module tb_seq_alu;
  logic clock = 1'b0;
  logic clear;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  seq_alu_if #(.WIDTH(32)) bus();
  seq_alu #(.WIDTH(32)) dut (.clock(clock), .clear(clear), .bus(bus));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          acc;
    int          due;
  } exp_t;
  exp_t sb[$];

  logic [31:0] last_hi, last_lo;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  // Monitor: samples 2 time units after each rising edge.
  always @(posedge clock) begin
    logic clr;
    logic busy_exp;
    exp_t e;
    clr = clear;
    #2;
    if (clr) begin
      last_hi = bus.ResultHi;
      last_lo = bus.ResultLo;
    end else begin
      busy_exp = (sb.size() != 0) && (cyc >= sb[0].acc) && (cyc < sb[0].due);
      chk("busy", {31'b0, bus.busy}, {31'b0, busy_exp});
      if (bus.done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_hi"}, bus.ResultHi, e.hi);
          chk({e.name, "_lo"}, bus.ResultLo, e.lo);
          chk({e.name, "_divzero"}, {31'b0, bus.div_zero}, {31'b0, e.dz});
          chk({e.name, "_latency"}, cyc, e.due);
          $display("done %s: hi=%h lo=%h dz=%0b at cycle %0d", e.name, bus.ResultHi, bus.ResultLo, bus.div_zero, cyc);
        end
      end else begin
        chk("divzero_idle", {31'b0, bus.div_zero}, 32'd0);
        chk("hi_stable", bus.ResultHi, last_hi);
        chk("lo_stable", bus.ResultLo, last_lo);
      end
      last_hi = bus.ResultHi;
      last_lo = bus.ResultLo;
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic issue(input string nm, input logic [4:0] op, input logic [31:0] ra,
                       input logic [31:0] rb, input int lat, input logic [31:0] ehi,
                       input logic [31:0] elo, input logic edz);
    exp_t e;
    int guard = 0;
    while (bus.busy && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 200) chk({nm, "_idle_timeout"}, 32'd1, 32'd0);
    e.name = nm; e.hi = ehi; e.lo = elo; e.dz = edz;
    e.acc = cyc + 1;
    e.due = cyc + 1 + lat;
    sb.push_back(e);
    bus.start = 1'b1; bus.Op = op; bus.RA = ra; bus.RB = rb;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  task automatic check_reset_state(input string nm);
    chk({nm, "_busy"}, {31'b0, bus.busy}, 32'd0);
    chk({nm, "_done"}, {31'b0, bus.done}, 32'd0);
    chk({nm, "_divzero"}, {31'b0, bus.div_zero}, 32'd0);
    chk({nm, "_hi"}, bus.ResultHi, 32'd0);
    chk({nm, "_lo"}, bus.ResultLo, 32'd0);
  endtask

  initial begin
    int guard;
    clear = 1'b1;
    bus.start = 1'b0; bus.Op = 5'd0; bus.RA = '0; bus.RB = '0;
    repeat (2) @(negedge clock);
    check_reset_state("reset");
    clear = 1'b0;
    @(negedge clock);

    // Single-cycle ops, issued back-to-back in each done cycle.
    issue("add",   5'b00011, 32'h7FFFFFFF, 32'h00000001, 1, 32'h0, 32'h80000000, 1'b0);
    issue("sub",   5'b00100, 32'h00000005, 32'h00000009, 1, 32'h0, 32'hFFFFFFFC, 1'b0);
    issue("shra",  5'b01010, 32'h80000000, 32'h00000024, 1, 32'h0, 32'hF8000000, 1'b0);
    issue("rol",   5'b01000, 32'h80000001, 32'h00000001, 1, 32'h0, 32'h00000003, 1'b0);
    issue("ror0",  5'b00111, 32'h12345678, 32'h00000020, 1, 32'h0, 32'h12345678, 1'b0);
    issue("ror4",  5'b00111, 32'h00000001, 32'h00000004, 1, 32'h0, 32'h10000000, 1'b0);
    issue("shla",  5'b10011, 32'h80000001, 32'h00000001, 1, 32'h0, 32'h80000002, 1'b0);
    issue("neg",   5'b10001, 32'h0000FFFF, 32'h00000001, 1, 32'h0, 32'hFFFFFFFF, 1'b0);
    issue("andi",  5'b01101, 32'hF0F0F0F0, 32'h0FF00FF0, 1, 32'h0, 32'h00F000F0, 1'b0);
    issue("undef", 5'b11111, 32'h00000005, 32'h00000006, 1, 32'h0, 32'h00000000, 1'b0);

    // Multiply and divide.
    issue("mul_m3x7",   5'b10000, 32'hFFFFFFFD, 32'h00000007, 32, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    issue("mul_minsq",  5'b10000, 32'h80000000, 32'h80000000, 32, 32'h40000000, 32'h00000000, 1'b0);
    issue("div_m7d2",   5'b01111, 32'hFFFFFFF9, 32'h00000002, 33, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    issue("div_7dm2",   5'b01111, 32'h00000007, 32'hFFFFFFFE, 33, 32'h00000001, 32'hFFFFFFFD, 1'b0);
    issue("div_mindm1", 5'b01111, 32'h80000000, 32'hFFFFFFFF, 33, 32'h00000000, 32'h80000000, 1'b0);
    issue("div_zero",   5'b01111, 32'h00001234, 32'h00000000, 1, 32'h00001234, 32'hFFFFFFFF, 1'b1);

    // Clear mid-MUL: outputs zero and the aborted MUL never completes.
    issue("mul_abort", 5'b10000, 32'h00000003, 32'h00000005, 32, 32'h0, 32'h0000000F, 1'b0);
    repeat (5) @(negedge clock);
    sb.delete();
    clear = 1'b1;
    bus.start = 1'b1; bus.Op = 5'b00011; bus.RA = 32'd1; bus.RB = 32'd1;
    @(negedge clock);
    bus.start = 1'b0;
    check_reset_state("clear_mid_mul");
    clear = 1'b0;
    repeat (40) @(negedge clock);

    // Start and operand changes during MUL_IT are ignored.
    issue("mul_busy", 5'b10000, 32'h00000006, 32'hFFFFFFF9, 32, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0);
    bus.start = 1'b1; bus.Op = 5'b00011; bus.RA = 32'h11111111; bus.RB = 32'h22222222;
    @(negedge clock);
    bus.RA = 32'h33333333;
    @(negedge clock);
    bus.start = 1'b0;
    bus.RA = 32'h44444444;

    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    chk("drain_pending", sb.size(), 32'd0);
    repeat (10) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
